udm_uart_rx_frontend: RTL

//  Serial receive front end of the UART debug master (udm). Oversamples rx_i, recovers 8N1/8E1/8O1 frames
//  and hands each byte to the udm protocol decoder as a one-cycle rx_done_tick_o strobe with dout_bo.

---
 rtl/udm_uart_pkg.sv | 19 +
 rtl/udm_uart_bit_timer.sv | 53 +++++
 rtl/udm_uart_rx_frontend.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/udm_uart_pkg.sv
// Shared definitions for the udm UART receive front end: parity codes, FSM states, divider floor.
package udm_uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned UART_MIN_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } rx_state_e;

endpackage

// File: rtl/udm_uart_bit_timer.sv
// Bit-period timer: latches the divider at start detect and emits the sample pulse(s) of each bit.
// With UDM_UART_RX_MAJORITY_EN it also emits pulses at s-1 and s, and the decision pulse moves to s+1.
module udm_uart_bit_timer
  import udm_uart_pkg::*;
#(
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned MIN_DIV = UART_MIN_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             active,
  input  logic             half,
  input  logic [DIV_W-1:0] cfg_div,
`ifdef UDM_UART_RX_MAJORITY_EN
  output logic             early,
  output logic             mid,
`endif
  output logic             tick
);

  localparam logic [DIV_W-1:0] MIN_L = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_l <= MIN_L;
      cnt   <= '0;
    end else if (start) begin
      div_l <= (cfg_div < MIN_L) ? MIN_L : cfg_div;
      cnt   <= '0;
    end else if (active) begin
      cnt <= tick ? '0 : cnt + ONE;
    end
  end

`ifdef UDM_UART_RX_MAJORITY_EN
  // decision lands one cycle after the nominal sample point
  assign tgt   = half ? (div_l >> 1) : div_l - ONE;
  assign early = active && (cnt == tgt - TWO);
  assign mid   = active && (cnt == tgt - ONE);
`else
  assign tgt   = half ? (div_l >> 1) - ONE : div_l - ONE;
`endif

  assign tick = active && (cnt == tgt);

endmodule

// File: rtl/udm_uart_rx_frontend.sv
// udm UART receive front end: recovers 8N1/8E1/8O1 frames from an oversampled rx line.
// Optional UDM_UART_RX_MAJORITY_EN: each bit decided by 2-of-3 vote around its sample point.
module udm_uart_rx_frontend
  import udm_uart_pkg::*;
#(
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned MIN_DIV = UART_MIN_DIV
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [1:0]       cfg_parity_i,
  output logic             rx_done_tick_o,
  output logic [7:0]       dout_bo,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  // state  | meaning
  // IDLE   | wait for falling edge     START | confirm start bit mid-period
  // DATA   | shift 8 bits, LSB first   PARITY | check parity bit (if enabled)
  // STOP   | check stop bit            BRK   | line held low, wait for high

  rx_state_e  state, state_nxt;
  logic       sync1, rxs, rxs_d;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [1:0] par_l;
  logic       par_err;
  logic       fall, start, active, half, tick, bit_val, par_on, par_exp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign fall    = rxs_d & ~rxs;
  assign start   = (state == IDLE) && fall;
  assign active  = state inside {START, DATA, PARITY, STOP};
  assign half    = (state == START);
  assign par_on  = (par_l == PAR_EVEN) || (par_l == PAR_ODD);
  assign par_exp = (par_l == PAR_ODD) ? ~^shreg : ^shreg;
  assign busy_o  = (state != IDLE);

`ifdef UDM_UART_RX_MAJORITY_EN
  logic early, mid, v_early, v_mid;

  udm_uart_bit_timer #(.DIV_W(DIV_W), .MIN_DIV(MIN_DIV)) u_timer (
    .clk(clk_i), .rst(rst_i), .start(start), .active(active), .half(half),
    .cfg_div(cfg_div_i), .early(early), .mid(mid), .tick(tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_early <= 1'b1;
      v_mid   <= 1'b1;
    end else begin
      if (early) v_early <= rxs;
      if (mid)   v_mid   <= rxs;
    end
  end

  assign bit_val = (v_early & v_mid) | (v_early & rxs) | (v_mid & rxs);
`else
  udm_uart_bit_timer #(.DIV_W(DIV_W), .MIN_DIV(MIN_DIV)) u_timer (
    .clk(clk_i), .rst(rst_i), .start(start), .active(active), .half(half),
    .cfg_div(cfg_div_i), .tick(tick)
  );

  assign bit_val = rxs;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (fall) state_nxt = START;
      START:   if (tick) state_nxt = bit_val ? IDLE : DATA;
      DATA:    if (tick && bit_cnt == 3'd7) state_nxt = par_on ? PARITY : STOP;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick) state_nxt = bit_val ? IDLE : BRK;
      BRK:     if (rxs)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      par_l          <= PAR_NONE;
      par_err        <= 1'b0;
      rx_done_tick_o <= 1'b0;
      dout_bo        <= '0;
      parity_err_o   <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      rx_done_tick_o <= 1'b0;
      parity_err_o   <= 1'b0;
      frame_err_o    <= 1'b0;
      if (start) begin
        par_l   <= cfg_parity_i;
        par_err <= 1'b0;
        bit_cnt <= '0;
      end
      if (tick) begin
        unique case (state)
          DATA: begin
            shreg   <= {bit_val, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_err <= (bit_val != par_exp);
          STOP: begin
            if (bit_val) begin
              rx_done_tick_o <= 1'b1;
              dout_bo        <= shreg;
              parity_err_o   <= par_err;
            end else begin
              frame_err_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
